// File: rtl/nbout_pack_ctrl.sv
// Sequencing controller for the NBout packer: derives shift/load/row-select per
// accepted value and hands completed (or flushed partial) rows to the write port.
module nbout_pack_ctrl #(
  parameter int BIT_WIDTH  = 16,
  parameter int SHIFT_BITS = 5,
  parameter int BIT_IDX    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cfg_load,
  input  logic [BIT_IDX-1:0]     i_n,
  input  logic                   i_valid,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic [SHIFT_BITS-1:0]  o_s,
  output logic [2*BIT_WIDTH-1:0] o_load,
  output logic                   o_row_sel,
  output logic                   o_out_valid,
  output logic [4:0]             o_out_nbits,
  input  logic                   i_out_ready
);

  localparam int REG_W = 2 * BIT_WIDTH;
  localparam int OFF_W = SHIFT_BITS - 1;

  logic [SHIFT_BITS-1:0] ptr, ptr_nxt;
  logic [SHIFT_BITS-1:0] p_reg, p_nxt;
  logic                  pending, pending_nxt;
  logic                  pend_row, pend_row_nxt;
  logic [4:0]            pend_bits, pend_bits_nxt;

  logic                  accept;
  logic [SHIFT_BITS:0]   fill_sum;
  logic                  row_done;
  logic [SHIFT_BITS-1:0] nptr;
  logic [OFF_W-1:0]      nptr_off;

  // Run of `width` ones starting at bit `base`, wrapping around the circular register.
  function automatic logic [REG_W-1:0] load_mask(input logic [SHIFT_BITS-1:0] base,
                                                 input logic [SHIFT_BITS-1:0] width);
    logic [REG_W-1:0]   run;
    logic [2*REG_W-1:0] spread;
    run = '0;
    for (int j = 0; j < REG_W; j++) begin
      run[j] = (j < int'(width));
    end
    spread = {{REG_W{1'b0}}, run} << base;
    return spread[REG_W-1:0] | spread[2*REG_W-1:REG_W];
  endfunction

  assign o_ready  = !rst && (!pending || i_out_ready);
  assign accept   = i_valid && o_ready;
  assign fill_sum = {2'b00, ptr[OFF_W-1:0]} + {1'b0, p_reg};
  assign row_done = fill_sum >= (SHIFT_BITS+1)'(BIT_WIDTH);
  assign nptr     = ptr + p_reg;
  assign nptr_off = nptr[OFF_W-1:0];

  assign o_s         = ptr;
  assign o_load      = accept ? load_mask(ptr, p_reg) : '0;
  assign o_row_sel   = pend_row;
  assign o_out_valid = pending;
  assign o_out_nbits = pend_bits;

  always_comb begin
    ptr_nxt       = ptr;
    p_nxt         = p_reg;
    pending_nxt   = pending;
    pend_row_nxt  = pend_row;
    pend_bits_nxt = pend_bits;

    if (pending && i_out_ready) begin
      pending_nxt = 1'b0;
    end

    if (accept) begin
      if (row_done) begin
        pending_nxt   = 1'b1;
        pend_row_nxt  = ptr[SHIFT_BITS-1];
        pend_bits_nxt = 5'(BIT_WIDTH);
      end else if (i_last && (nptr_off != '0)) begin
        // Partial row on flush: only the bits filled so far are meaningful.
        pending_nxt   = 1'b1;
        pend_row_nxt  = ptr[SHIFT_BITS-1];
        pend_bits_nxt = 5'(nptr_off);
      end
      ptr_nxt = i_last ? '0 : nptr;
    end else if (i_cfg_load && (ptr == '0) && !pending) begin
      p_nxt = SHIFT_BITS'(i_n) + SHIFT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      p_reg     <= SHIFT_BITS'(BIT_WIDTH);
      pending   <= 1'b0;
      pend_row  <= 1'b0;
      pend_bits <= 5'(BIT_WIDTH);
    end else begin
      ptr       <= ptr_nxt;
      p_reg     <= p_nxt;
      pending   <= pending_nxt;
      pend_row  <= pend_row_nxt;
      pend_bits <= pend_bits_nxt;
    end
  end

endmodule

// File: tb/tb_nbout_pack_ctrl.sv
// Randomized plus directed bench for nbout_pack_ctrl against an arithmetic
// model of the packing-register fill rules.
module tb_nbout_pack_ctrl;

  logic        clk;
  logic        rst;
  logic        i_cfg_load;
  logic [3:0]  i_n;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic [4:0]  o_s;
  logic [31:0] o_load;
  logic        o_row_sel;
  logic        o_out_valid;
  logic [4:0]  o_out_nbits;
  logic        i_out_ready;

  nbout_pack_ctrl #(.BIT_WIDTH(16), .SHIFT_BITS(5), .BIT_IDX(4)) dut (
    .clk(clk), .rst(rst), .i_cfg_load(i_cfg_load), .i_n(i_n),
    .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready), .o_s(o_s),
    .o_load(o_load), .o_row_sel(o_row_sel), .o_out_valid(o_out_valid),
    .o_out_nbits(o_out_nbits), .i_out_ready(i_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit m_known = 0;
  int m_ptr, m_p, m_row, m_bits;
  bit m_pend;

  // last observed outputs
  logic [31:0] obs_load;
  logic [4:0]  obs_s, obs_bits;
  logic        obs_rdy, obs_vld, obs_row;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit l, input bit cfg,
                      input int n, input bit ordy);
    bit          e_rdy, acc, done, flush_part;
    logic [31:0] e_load;
    int          np;
    rst = r; i_valid = v; i_last = l; i_cfg_load = cfg;
    i_n = 4'(n); i_out_ready = ordy;
    @(negedge clk);
    obs_rdy = o_ready; obs_s = o_s; obs_load = o_load;
    obs_vld = o_out_valid; obs_row = o_row_sel; obs_bits = o_out_nbits;

    e_rdy  = !r && (!m_pend || ordy);
    acc    = v && e_rdy;
    e_load = '0;
    if (acc) for (int j = 0; j < m_p; j++) e_load[(m_ptr + j) % 32] = 1'b1;

    if (m_known) begin
      chk("ready", 32'(obs_rdy), 32'(e_rdy));
      chk("s", 32'(obs_s), 32'(m_ptr));
      chk("load", obs_load, e_load);
      chk("out_valid", 32'(obs_vld), 32'(m_pend));
      chk("row_sel", 32'(obs_row), 32'(m_row));
      chk("nbits", 32'(obs_bits), 32'(m_bits));
    end

    if (r) begin
      m_ptr = 0; m_p = 16; m_pend = 0; m_row = 0; m_bits = 16; m_known = 1;
    end else begin
      bit old_pend = m_pend;
      int old_ptr  = m_ptr;
      if (m_pend && ordy) m_pend = 0;
      if (acc) begin
        np         = (m_ptr + m_p) % 32;
        done       = (m_ptr % 16) + m_p >= 16;
        flush_part = !done && l && (np % 16) != 0;
        if (done || flush_part) begin
          m_pend = 1;
          m_row  = m_ptr / 16;
          m_bits = done ? 16 : np % 16;
        end
        m_ptr = l ? 0 : np;
      end else if (cfg && old_ptr == 0 && !old_pend) begin
        m_p = n + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; i_valid = 0; i_last = 0; i_cfg_load = 0; i_n = 0; i_out_ready = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0);

    // reset state
    step(0, 0, 0, 0, 0, 1);
    chk("rst_ready", 32'(obs_rdy), 32'd1);
    chk("rst_s", 32'(obs_s), 32'd0);
    chk("rst_load", obs_load, 32'd0);
    chk("rst_vld", 32'(obs_vld), 32'd0);
    chk("rst_nbits", 32'(obs_bits), 32'd16);

    // p=16 full throughput
    step(0, 0, 0, 1, 15, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 0, 1);
      chk("p16_s", 32'(obs_s), (k % 2) ? 32'd16 : 32'd0);
      chk("p16_load", obs_load, (k % 2) ? 32'hFFFF0000 : 32'h0000FFFF);
      if (k > 0) begin
        chk("p16_vld", 32'(obs_vld), 32'd1);
        chk("p16_row", 32'(obs_row), 32'((k - 1) % 2));
      end
    end
    step(0, 0, 0, 0, 0, 1);
    chk("p16_vld_last", 32'(obs_vld), 32'd1);
    chk("p16_row_last", 32'(obs_row), 32'd1);

    // p=5
    step(0, 0, 0, 1, 4, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 0, 1);
      chk("p5_s", 32'(obs_s), 32'(5 * k));
    end
    chk("p5_load4", obs_load, 32'h000F8000);
    step(0, 1, 1, 0, 0, 1);
    chk("p5_ptr20", 32'(obs_s), 32'd20);
    chk("p5_vld", 32'(obs_vld), 32'd1);
    chk("p5_row0", 32'(obs_row), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("p5_flush_row", 32'(obs_row), 32'd1);
    chk("p5_flush_bits", 32'(obs_bits), 32'd9);

    // p=12 wrap
    step(0, 0, 0, 1, 11, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("p12_s", 32'(obs_s), 32'd24);
    chk("p12_load", obs_load, 32'hFF00000F);
    chk("p12_row0", 32'(obs_row), 32'd0);
    step(0, 1, 1, 0, 0, 1);
    chk("p12_ptr4", 32'(obs_s), 32'd4);
    chk("p12_row1", 32'(obs_row), 32'd1);
    step(0, 0, 0, 0, 0, 1);

    // backpressure p=16
    step(0, 0, 0, 1, 15, 1);
    step(0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("bp_ready", 32'(obs_rdy), 32'd0);
      chk("bp_row", 32'(obs_row), 32'd0);
      chk("bp_s", 32'(obs_s), 32'd16);
    end
    step(0, 1, 0, 0, 0, 1);
    chk("bp_resume_rdy", 32'(obs_rdy), 32'd1);
    chk("bp_resume_load", obs_load, 32'hFFFF0000);
    step(0, 1, 1, 0, 0, 1);
    chk("bp_row1", 32'(obs_row), 32'd1);
    step(0, 0, 0, 0, 0, 1);

    // flush p=3, cfg blocked while pending
    step(0, 0, 0, 1, 2, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("fl_bits", 32'(obs_bits), 32'd9);
    chk("fl_row", 32'(obs_row), 32'd0);
    chk("fl_ptr", 32'(obs_s), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    chk("fl_cfg_ignored", obs_load, 32'h00000007);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 7, 1);
    step(0, 1, 1, 0, 0, 1);
    chk("fl_cfg_taken", obs_load, 32'h000000FF);
    step(0, 0, 0, 0, 0, 1);

    // reset mid-stream with ptr=20, row pending
    step(0, 0, 0, 1, 4, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("mr_pre_ptr", 32'(obs_s), 32'd20);
    chk("mr_pre_vld", 32'(obs_vld), 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("mr_ptr", 32'(obs_s), 32'd0);
    chk("mr_vld", 32'(obs_vld), 32'd0);
    step(0, 1, 0, 0, 0, 1);
    chk("mr_p16", obs_load, 32'h0000FFFF);

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 99) == 0),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
